l1_trigger_qualifier: RTL and testbench

//  Parametrised successor stage to the L1 beam trigger. Takes raw per-beam trigger bits from the

---
 rtl/l1_trigger_qualifier.sv | 177 +++++++++++++++++
 tb/tb_l1_trigger_qualifier.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_trigger_qualifier.sv
// l1_trigger_qualifier
//
// Qualifies raw per-beam triggers from the beamformer and forms the global
// L1 decision. Each beam is masked and registered. A qualified beam trigger
// then starts that beam's holdoff, which suppresses further pulses from the
// beam for holdoff_i cycles. The global L1 is formed from the qualified beams,
// either as an OR or as an M-of-N majority. Saturating per-beam rate scalers
// count qualified pulses over a programmable gate. At the end of each gate the
// counts are latched into a bank. The bank can be read one beam at a time
// through a registered mux.
//
// Ports
//   aclk          clock, all logic synchronous to it
//   reset_i       asynchronous active-high reset
//   beam_trig_i   raw beam triggers, one level per cycle
//   mask_i        1 disables the corresponding beam
//   mode_i        0 = global OR, 1 = majority
//   majority_i    majority threshold M, 0 behaves as 1
//   holdoff_i     dead cycles after each qualified beam trigger
//   period_i      scaler gate length minus 1, in aclk cycles
//   scal_sel_i    beam index for scaler readout
//   trigger_o     qualified per-beam trigger pulses
//   l1_o          global L1 trigger pulse
//   scal_o        latched scaler of beam scal_sel_i
//   scal_valid_o  one-cycle pulse when a new scaler set has been latched

module l1_trigger_qualifier #(
  parameter int NBEAMS       = 2,
  parameter int HOLDOFF_BITS = 8,
  parameter int PERIOD_BITS  = 24,
  parameter int SCALER_BITS  = 16,
  localparam int SELW        = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
  localparam int MAJW        = $clog2(NBEAMS + 1)
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       beam_trig_i,
  input  logic [NBEAMS-1:0]       mask_i,
  input  logic                    mode_i,
  input  logic [MAJW-1:0]         majority_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [PERIOD_BITS-1:0]  period_i,
  input  logic [SELW-1:0]         scal_sel_i,
  output logic [NBEAMS-1:0]       trigger_o,
  output logic                    l1_o,
  output logic [SCALER_BITS-1:0]  scal_o,
  output logic                    scal_valid_o
);

  logic [NBEAMS-1:0]       m_q;
  logic [HOLDOFF_BITS-1:0] hc_q     [NBEAMS];
  logic [SCALER_BITS-1:0]  cnt_q    [NBEAMS];
  logic [SCALER_BITS-1:0]  bank_q   [NBEAMS];
  logic [SCALER_BITS-1:0]  cnt_next [NBEAMS];
  logic [PERIOD_BITS-1:0]  gate_q;
  logic [MAJW-1:0]         n_trig;
  logic [MAJW-1:0]         thresh;
  logic                    gate_end;
  logic [SCALER_BITS-1:0]  sel_bank;

  // Input stage: drop masked beams and register the rest, so the holdoff
  // logic only ever sees a clean, registered view of the enabled beams.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      m_q <= '0;
    end else begin
      m_q <= beam_trig_i & ~mask_i;
    end
  end

  // Per-beam holdoff. A running countdown always wins over a new trigger.
  // This makes the beam dead for exactly holdoff_i cycles after each pulse.
  // holdoff_i is sampled only when the counter is loaded, so changing it
  // never disturbs a countdown that is already in progress.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      trigger_o <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        hc_q[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (hc_q[b] != '0) begin
          trigger_o[b] <= 1'b0;
          hc_q[b]      <= hc_q[b] - 1'b1;
        end else if (m_q[b]) begin
          trigger_o[b] <= 1'b1;
          hc_q[b]      <= holdoff_i;
        end else begin
          trigger_o[b] <= 1'b0;
        end
      end
    end
  end

  // Count the qualified beams firing this cycle. A threshold of zero is
  // promoted to one, so majority mode never fires on an empty cycle.
  always_comb begin
    n_trig = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      n_trig = n_trig + MAJW'(trigger_o[b]);
    end
    thresh = (majority_i == '0) ? MAJW'(1) : majority_i;
  end

  // Global L1 decision. A threshold above NBEAMS can never be reached,
  // because n_trig is at most NBEAMS.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      l1_o <= 1'b0;
    end else if (mode_i) begin
      l1_o <= (n_trig >= thresh);
    end else begin
      l1_o <= (n_trig != '0);
    end
  end

  // Saturating next count for each beam. The same value feeds both the
  // running counter and the bank, so a pulse on the terminal cycle is still
  // counted in the period that is closing.
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      cnt_next[b] = (cnt_q[b] == '1) ? cnt_q[b] : cnt_q[b] + SCALER_BITS'(trigger_o[b]);
    end
    gate_end = (gate_q >= period_i);
  end

  // Gate counter and scaler bank. The terminal test uses >= so that lowering
  // period_i below the current count closes the gate on the next cycle
  // instead of waiting for the counter to wrap.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      gate_q       <= '0;
      scal_valid_o <= 1'b0;
      for (int b = 0; b < NBEAMS; b++) begin
        cnt_q[b]  <= '0;
        bank_q[b] <= '0;
      end
    end else begin
      scal_valid_o <= gate_end;
      if (gate_end) begin
        gate_q <= '0;
        for (int b = 0; b < NBEAMS; b++) begin
          bank_q[b] <= cnt_next[b];
          cnt_q[b]  <= '0;
        end
      end else begin
        gate_q <= gate_q + 1'b1;
        for (int b = 0; b < NBEAMS; b++) begin
          cnt_q[b] <= cnt_next[b];
        end
      end
    end
  end

  // Readout mux. Selecting a beam that does not exist reads back zero
  // rather than aliasing onto another beam.
  always_comb begin
    sel_bank = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (scal_sel_i == SELW'(b)) begin
        sel_bank = bank_q[b];
      end
    end
  end

  // Register the readout. A freshly latched bank therefore appears on
  // scal_o one cycle after scal_valid_o.
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      scal_o <= '0;
    end else begin
      scal_o <= sel_bank;
    end
  end

endmodule

// File: tb/tb_l1_trigger_qualifier.sv
// tb_l1_trigger_qualifier
//
// Directed scenarios followed by a randomized run. Each cycle's outputs are
// compared against a behavioural model. The model tracks each beam's holdoff
// as an "earliest allowed edge" rather than as a countdown. It tracks the
// scaler gate as the edge index at which the current gate started.

module tb_l1_trigger_qualifier;

  localparam int NB   = 4;
  localparam int HB   = 8;
  localparam int PB   = 8;
  localparam int SB   = 4;
  localparam int SMAX = (1 << SB) - 1;

  logic          aclk = 1'b0;
  logic          reset_i;
  logic [NB-1:0] beam_trig_i;
  logic [NB-1:0] mask_i;
  logic          mode_i;
  logic [2:0]    majority_i;
  logic [HB-1:0] holdoff_i;
  logic [PB-1:0] period_i;
  logic [1:0]    scal_sel_i;
  logic [NB-1:0] trigger_o;
  logic          l1_o;
  logic [SB-1:0] scal_o;
  logic          scal_valid_o;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  int        edge_idx = 0;
  bit [NB-1:0] e_m;
  bit [NB-1:0] e_trig;
  bit        e_l1;
  bit        e_valid;
  int        e_scal;
  int        next_ok [NB];
  int        cnt     [NB];
  int        bank    [NB];
  int        gate_start;

  l1_trigger_qualifier #(
    .NBEAMS(NB), .HOLDOFF_BITS(HB), .PERIOD_BITS(PB), .SCALER_BITS(SB)
  ) dut (
    .aclk(aclk), .reset_i(reset_i), .beam_trig_i(beam_trig_i), .mask_i(mask_i),
    .mode_i(mode_i), .majority_i(majority_i), .holdoff_i(holdoff_i),
    .period_i(period_i), .scal_sel_i(scal_sel_i), .trigger_o(trigger_o),
    .l1_o(l1_o), .scal_o(scal_o), .scal_valid_o(scal_valid_o)
  );

  // Free-running clock.
  always #5 aclk = ~aclk;

  task automatic check_one(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_m = '0; e_trig = '0; e_l1 = 1'b0; e_valid = 1'b0; e_scal = 0;
    for (int b = 0; b < NB; b++) begin
      next_ok[b] = 0; cnt[b] = 0; bank[b] = 0;
    end
    gate_start = edge_idx;
  endtask

  task automatic model_step();
    int k, n, thr, s;
    bit terminal;
    bit [NB-1:0] nt;
    k = edge_idx;
    edge_idx++;
    if (reset_i) begin
      model_reset();
      return;
    end
    n = 0;
    for (int b = 0; b < NB; b++) n += e_trig[b];
    thr = (majority_i == 0) ? 1 : int'(majority_i);
    e_scal = (scal_sel_i < NB) ? bank[scal_sel_i] : 0;
    terminal = ((k - gate_start) >= int'(period_i));
    for (int b = 0; b < NB; b++) begin
      s = cnt[b] + e_trig[b];
      if (s > SMAX) s = SMAX;
      if (terminal) begin bank[b] = s; cnt[b] = 0; end
      else cnt[b] = s;
    end
    if (terminal) gate_start = k + 1;
    e_valid = terminal;
    e_l1 = mode_i ? (n >= thr) : (n > 0);
    nt = '0;
    for (int b = 0; b < NB; b++) begin
      if (e_m[b] && k >= next_ok[b]) begin
        nt[b] = 1'b1;
        next_ok[b] = k + int'(holdoff_i) + 1;
      end
    end
    e_trig = nt;
    e_m = beam_trig_i & ~mask_i;
  endtask

  task automatic checkOutput();
    check_one("trigger_o", trigger_o, e_trig);
    check_one("l1_o", l1_o, e_l1);
    check_one("scal_valid_o", scal_valid_o, e_valid);
    check_one("scal_o", scal_o, e_scal);
  endtask

  task automatic applyStimulus(input logic [NB-1:0] beams);
    beam_trig_i = beams;
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    model_reset();
    checkOutput();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; beam_trig_i = '0; mask_i = '0; mode_i = 1'b0;
    majority_i = 3'd1; holdoff_i = 8'd3; period_i = 8'd255; scal_sel_i = 2'd0;
    @(posedge aclk);
    #1;
    do_reset();

    $display("[TB] held beam 0 with holdoff 3");
    applyStimulus(4'b0001);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_one("t1_spacing", trigger_o[0], ((i >= 2) && ((i - 2) % 4 == 0)) ? 1 : 0);
    end
    applyStimulus(4'b0000);
    repeat (4) tick();

    $display("[TB] majority 3 of 4");
    holdoff_i = 8'd0; mode_i = 1'b1; majority_i = 3'd3;
    do_reset();
    applyStimulus(4'b0111); tick();
    applyStimulus(4'b0000); tick(); tick();
    check_one("t2_maj3_hit", l1_o, 1);
    tick();
    applyStimulus(4'b0011); tick();
    applyStimulus(4'b0000); tick(); tick();
    check_one("t2_maj3_miss", l1_o, 0);

    $display("[TB] masked beam 1");
    mode_i = 1'b0; mask_i = 4'b0010; period_i = 8'd0; scal_sel_i = 2'd1;
    applyStimulus(4'b0010);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_one("t3_trig1", trigger_o[1], 0);
      check_one("t3_l1", l1_o, 0);
    end
    check_one("t3_scal1", scal_o, 0);

    $display("[TB] ten pulses in a 100-cycle gate");
    mask_i = '0; period_i = 8'd99; scal_sel_i = 2'd0;
    applyStimulus(4'b0000);
    do_reset();
    for (int i = 1; i <= 101; i++) begin
      applyStimulus((i <= 20 && (i % 2 == 1)) ? 4'b0001 : 4'b0000);
      tick();
      if (i == 99)  check_one("t4_valid_early", scal_valid_o, 0);
      if (i == 100) check_one("t4_valid", scal_valid_o, 1);
    end
    check_one("t4_scal0", scal_o, 10);
    scal_sel_i = 2'd1;
    tick();
    check_one("t4_scal1", scal_o, 0);

    $display("[TB] scaler saturation");
    scal_sel_i = 2'd0; period_i = 8'd60;
    do_reset();
    for (int i = 1; i <= 62; i++) begin
      applyStimulus((i <= 40) ? 4'b0001 : 4'b0000);
      tick();
      if (i == 61) check_one("t5_valid", scal_valid_o, 1);
    end
    check_one("t5_saturate", scal_o, SMAX);

    $display("[TB] reset mid-holdoff and mid-gate");
    holdoff_i = 8'd20;
    applyStimulus(4'b0001);
    tick(); tick();
    check_one("t6_pre_trig", trigger_o[0], 1);
    reset_i = 1'b1;
    #1;
    model_reset();
    check_one("t6_async_trig", trigger_o, 0);
    check_one("t6_async_scal", scal_o, 0);
    tick();
    period_i = 8'd3;
    reset_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) check_one("t6_no_early", trigger_o[0], 0);
      if (i == 2) check_one("t6_first_pulse", trigger_o[0], 1);
      if (i == 3) check_one("t6_gate_running", scal_valid_o, 0);
      if (i == 4) check_one("t6_gate_restart", scal_valid_o, 1);
      if (i == 5) check_one("t6_fresh_count", scal_o, 1);
    end

    $display("[TB] randomized run");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(4'($urandom));
      if (i % 40 == 0) begin
        mode_i     = 1'($urandom);
        majority_i = 3'($urandom);
        holdoff_i  = 8'($urandom_range(0, 6));
        mask_i     = 4'($urandom) & 4'($urandom);
      end
      if (i % 97 == 0) period_i = 8'($urandom_range(0, 30));
      scal_sel_i = 2'($urandom);
      if (i == 300) do_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
